// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, optional two-entry skid buffer,
// flush, NOP payload on empty slots and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W = 64,
  parameter bit                   SKID_EN   = 1'b1,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [1:0]           occ_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  input  logic                 stall_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 main_valid;
  logic                 main_valid_n;
  logic [PAYLOAD_W-1:0] main_data;
  logic [PAYLOAD_W-1:0] main_data_n;
  logic                 skid_valid;
  logic                 skid_valid_n;
  logic [PAYLOAD_W-1:0] skid_data;
  logic [PAYLOAD_W-1:0] skid_data_n;
  logic [1:0]           occ_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic                 accept;
  logic                 send;

  // With the skid buffer, ready is purely a function of stored state.
  assign in_ready_o  = SKID_EN ? !skid_valid : (!main_valid || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign send        = main_valid && out_ready_i;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_valid ? main_data : NOP_VALUE;
  assign occ_o       = occ_q;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush_i) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (SKID_EN) begin
      if (!main_valid || send) begin
        if (skid_valid) begin
          main_valid_n = 1'b1;
          main_data_n  = skid_data;
          skid_valid_n = accept;
          if (accept) skid_data_n = in_data_i;
        end else begin
          main_valid_n = accept;
          if (accept) main_data_n = in_data_i;
        end
      end else if (accept) begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data_i;
      end
    end else begin
      skid_valid_n = 1'b0;
      if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data_i;
      end else if (send) begin
        main_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= NOP_VALUE;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      occ_q      <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end
  end

  // Clear wins over a same-cycle increment; flush leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
